rf_wb_arbiter: RTL
==================

// Module: rf_wb_arbiter
// PURPOSE
//  Write-back controller for the 32x32 register file's single write port.
//  Arbitrates two write-back requesters (0: ALU, 1: load unit) round-robin over valid/ready.
//  Drives a registered write port (oWe/oWaddr/oWdata) straight into regfile iWe/iWaddr/iWdata.
//  Holds a pending-write scoreboard so issue logic can stall on RAW hazards.
// PARAMETERS
//  DATA_W  32  write data width
//  ADDR_W  5   register address width
//  NREG    32  register count, = 2**ADDR_W; entry 0 is hard-wired zero
// PORTS
//  iClk        in   1       clock, all state on rising edge
//  iRstn       in   1       reset, asynchronous, active-low
//  iReq0Valid  in   1       requester 0 has a write
//  iReq0Addr   in   ADDR_W  requester 0 destination
//  iReq0Data   in   DATA_W  requester 0 data
//  oReq0Ready  out  1       requester 0 accepted this cycle (valid&ready = transfer)
//  iReq1Valid  in   1       requester 1 has a write
//  iReq1Addr   in   ADDR_W  requester 1 destination
//  iReq1Data   in   DATA_W  requester 1 data
//  oReq1Ready  out  1       requester 1 accepted this cycle
//  iRsvValid   in   1       issue stage reserves a destination
//  iRsvAddr    in   ADDR_W  reserved destination
//  iChkAddr1   in   ADDR_W  hazard query source 1
//  iChkAddr2   in   ADDR_W  hazard query source 2
//  oBusy1      out  1       iChkAddr1 has a write outstanding
//  oBusy2      out  1       iChkAddr2 has a write outstanding
//  oWe         out  1       regfile write enable (registered)
//  oWaddr      out  ADDR_W  regfile write address (registered)
//  oWdata      out  DATA_W  regfile write data (registered)
//  oIdle       out  1       no busy bits set and oWe==0
// BEHAVIOUR
//  Reset (iRstn=0, async, any time incl. mid-transfer): oWe=0, oWaddr=0, oWdata=0, all busy=0,
//   rr pointer=0. Readies still follow the comb rule below; transfers while in reset are dropped.
//   Regfile contents are not touched by this block.
//  Arbitration (combinational, no dependency on downstream; port always accepts):
//   one valid -> that requester ready; both valid -> requester rr ready, other 0; none -> both 0.
//   At most one ready high per cycle.
//  rr update on each transfer: rr <= ~granted index. No transfer -> rr holds.
//  Write stage, latency 1: transfer at edge t -> oWe=1, oWaddr/oWdata = granted addr/data
//   during cycle t+1. No transfer -> oWe=0; oWaddr/oWdata hold last value.
//  Address 0: transfer accepted normally (ready asserted, rr updates) but oWe stays 0.
//  Back-to-back: one accepted write per cycle, full throughput, no bubbles.
//  Scoreboard busy[NREG-1:1], busy[0] constant 0:
//   set   at edge when iRsvValid && iRsvAddr!=0;
//   clear at edge when oWe==1, index oWaddr (same edge the regfile commits the data);
//   set and clear on same index, same edge -> set wins (new reservation stays outstanding);
//   reserving an already-busy index -> stays busy (no counting; WAW ordering is issue's job).
//  oBusyN = busy[iChkAddrN], combinational from registered state; address 0 always 0.
//   Cycle after clear, regfile read returns the new value (no forwarding needed).
//  Data width: no arithmetic; addr/data passed bit-exact.
// STRUCTURE
//  Package rf_ctrl_pkg: DATA_W, ADDR_W, NREG constants; typedef wb_req_t {addr, data};
//   typedef enum logic {REQ_ALU=0, REQ_LD=1} req_id_e.
//  Sub-module rf_scoreboard: busy array, set/clear/priority logic, two query ports.
//  Top: arbiter + rr flop + write-stage register; instantiates rf_scoreboard.
// TESTING
//  T1 reset: mid-stream pull iRstn=0 with oWe=1 -> oWe=0, oBusy1/2=0, oIdle=1 immediately, async.
//  T2 single: req0 addr 5 data 32'hDEADBEEF -> oReq0Ready=1 same cycle; next cycle oWe=1,
//     oWaddr=5, oWdata=DEADBEEF; following cycle oWe=0.
//  T3 contention: both valid 4 cycles from reset, addrs 1/2 -> grants 0,1,0,1; oWaddr 1,2,1,2.
//  T4 x0: req1 addr 0 data 32'h1234 -> oReq1Ready=1, oWe stays 0, rr moves to 0.
//  T5 scoreboard: rsv 7 -> oBusy1(chk 7)=1 next cycle; req0 write 7 accepted at t -> oBusy1 still
//     1 during t+1 (oWe=1), 0 at t+2; rsv 7 on the commit edge -> oBusy1 stays 1.
//  T6 rsv addr 0 -> oBusy1(chk 0)=0, oIdle stays 1.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared widths and types for the register-file write-back path
package rf_ctrl_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
    typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_id_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with two hazard query ports
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              any_busy
);
    logic [NREG-1:0] busy_q, busy_d;

    // set is applied after clear so a reservation on the commit edge stays outstanding
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy1    = busy_q[chk_addr1];
    assign busy2    = busy_q[chk_addr2];
    assign any_busy = |busy_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbitration of ALU/load write-backs into a registered
// regfile write port, plus the RAW-hazard scoreboard
module rf_wb_arbiter
    import rf_ctrl_pkg::*;
(
    input  logic              iClk,
    input  logic              iRstn,
    input  logic              iReq0Valid,
    input  logic [ADDR_W-1:0] iReq0Addr,
    input  logic [DATA_W-1:0] iReq0Data,
    output logic              oReq0Ready,
    input  logic              iReq1Valid,
    input  logic [ADDR_W-1:0] iReq1Addr,
    input  logic [DATA_W-1:0] iReq1Data,
    output logic              oReq1Ready,
    input  logic              iRsvValid,
    input  logic [ADDR_W-1:0] iRsvAddr,
    input  logic [ADDR_W-1:0] iChkAddr1,
    input  logic [ADDR_W-1:0] iChkAddr2,
    output logic              oBusy1,
    output logic              oBusy2,
    output logic              oWe,
    output logic [ADDR_W-1:0] oWaddr,
    output logic [DATA_W-1:0] oWdata,
    output logic              oIdle
);
    wb_req_t           req0, req1, sel;
    req_id_e           rr_q, rr_d, gnt;
    logic              xfer;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              any_busy;

    assign req0 = {iReq0Addr, iReq0Data};
    assign req1 = {iReq1Addr, iReq1Data};

    // the write port never back-pressures, so readiness depends only on valids and rr
    always_comb begin
        oReq0Ready = iReq0Valid && (!iReq1Valid || rr_q == REQ_ALU);
        oReq1Ready = iReq1Valid && (!iReq0Valid || rr_q == REQ_LD);
        xfer       = oReq0Ready || oReq1Ready;
        gnt        = oReq1Ready ? REQ_LD : REQ_ALU;
        sel        = oReq1Ready ? req1 : req0;
        rr_d       = xfer ? (gnt == REQ_ALU ? REQ_LD : REQ_ALU) : rr_q;
        we_d       = xfer && sel.addr != '0;
        waddr_d    = we_d ? sel.addr : waddr_q;
        wdata_d    = we_d ? sel.data : wdata_q;
    end

    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            rr_q    <= REQ_ALU;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    rf_scoreboard u_sb (
        .clk      (iClk),
        .rst_n    (iRstn),
        .set_en   (iRsvValid),
        .set_addr (iRsvAddr),
        .clr_en   (we_q),
        .clr_addr (waddr_q),
        .chk_addr1(iChkAddr1),
        .chk_addr2(iChkAddr2),
        .busy1    (oBusy1),
        .busy2    (oBusy2),
        .any_busy (any_busy)
    );

    assign oWe    = we_q;
    assign oWaddr = waddr_q;
    assign oWdata = wdata_q;
    assign oIdle  = !any_busy && !we_q;
endmodule
